// File: rtl/alu.sv
// Execute-stage integer ALU: decodes the func nibble of the instruction word and
// registers a 32-bit result plus {SF,ZF,CF,OF} flags one cycle after the inputs.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_ir,
    input  logic [31:0] sr,
    input  logic [31:0] tr,
    output logic [31:0] alu_dr,
    output logic [3:0]  alu_fl
);

    typedef enum logic [3:0] {
        F_NOP = 4'h0,
        F_LIL = 4'h1,
        F_MOV = 4'h2,
        F_ADD = 4'h3,
        F_SUB = 4'h4,
        F_CMP = 4'h5,
        F_AND = 4'h6,
        F_OR  = 4'h7,
        F_XOR = 4'h8,
        F_NEG = 4'h9,
        F_NOT = 4'hA,
        F_SLL = 4'hB,
        F_SLA = 4'hC,
        F_SRL = 4'hD,
        F_SRA = 4'hE,
        F_RSV = 4'hF
    } func_e;

    func_e       func;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        unused_ir_bits;

    assign func           = func_e'(alu_ir[31:28]);
    assign shamt          = alu_ir[12:8];
    assign imm            = alu_ir[15:0];
    assign unused_ir_bits = ^alu_ir[27:16];

    logic [31:0] dr_q, dr_d;
    logic [3:0]  fl_q, fl_d;

    // 33-bit forms expose carry/borrow in bit 32 of the sum/difference.
    logic [32:0] add_full;
    logic [32:0] sub_full;
    logic [31:0] neg_res;
    logic        add_of;
    logic        sub_of;

    assign add_full = {1'b0, tr} + {1'b0, sr};
    assign sub_full = {1'b0, tr} - {1'b0, sr};
    assign neg_res  = 32'd0 - tr;
    assign add_of   = (tr[31] == sr[31]) && (add_full[31] != tr[31]);
    assign sub_of   = (tr[31] != sr[31]) && (sub_full[31] != tr[31]);

    // Shifters carry one guard bit so the last bit shifted out lands there (0 when shamt==0).
    logic [32:0]        shl_full;
    logic [32:0]        shr_full;
    logic signed [32:0] sra_full;

    assign shl_full = {1'b0, tr} << shamt;
    assign shr_full = {tr, 1'b0} >> shamt;
    assign sra_full = $signed({tr, 1'b0}) >>> shamt;

    // SLA overflow: any bit in tr[31:31-shamt] disagreeing with the original sign.
    logic [31:0] sla_mismatch;
    logic        sla_of;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sla_ovf
            assign sla_mismatch[gi] = (tr[gi] != tr[31])
                                   && (({1'b0, shamt} + 6'(gi)) >= 6'd31);
        end
    endgenerate

    assign sla_of = |sla_mismatch;

    logic [31:0] res;
    logic        flag_upd;
    logic        cf;
    logic        of;

    always_comb begin
        res      = 32'd0;
        flag_upd = 1'b0;
        cf       = 1'b0;
        of       = 1'b0;
        unique case (func)
            F_NOP: res = 32'd0;
            F_LIL: res = {{16{imm[15]}}, imm};
            F_MOV: res = sr;
            F_ADD: begin
                res      = add_full[31:0];
                flag_upd = 1'b1;
                cf       = add_full[32];
                of       = add_of;
            end
            F_SUB, F_CMP: begin
                res      = sub_full[31:0];
                flag_upd = 1'b1;
                cf       = sub_full[32];
                of       = sub_of;
            end
            F_AND: begin
                res      = tr & sr;
                flag_upd = 1'b1;
            end
            F_OR: begin
                res      = tr | sr;
                flag_upd = 1'b1;
            end
            F_XOR: begin
                res      = tr ^ sr;
                flag_upd = 1'b1;
            end
            F_NEG: begin
                res      = neg_res;
                flag_upd = 1'b1;
                cf       = (tr != 32'd0);
                of       = (tr == 32'h8000_0000);
            end
            F_NOT: res = ~tr;
            F_SLL: begin
                res      = shl_full[31:0];
                flag_upd = 1'b1;
                cf       = shl_full[32];
            end
            F_SLA: begin
                res      = shl_full[31:0];
                flag_upd = 1'b1;
                cf       = shl_full[32];
                of       = sla_of;
            end
            F_SRL: begin
                res      = shr_full[32:1];
                flag_upd = 1'b1;
                cf       = shr_full[0];
            end
            F_SRA: begin
                res      = sra_full[32:1];
                flag_upd = 1'b1;
                cf       = sra_full[0];
            end
            F_RSV: res = 32'd0;
            default: res = 32'd0;
        endcase
    end

    always_comb begin
        dr_d = res;
        fl_d = fl_q;
        if (flag_upd) begin
            fl_d = {res[31], (res == 32'd0), cf, of};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_q <= 32'd0;
            fl_q <= 4'd0;
        end else begin
            dr_q <= dr_d;
            fl_q <= fl_d;
        end
    end

    assign alu_dr = dr_q;
    assign alu_fl = fl_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: each vector is applied for one edge and the
// registered result and flags ({SF,ZF,CF,OF}) are compared with hand-computed values.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] alu_ir;
    logic [31:0] sr;
    logic [31:0] tr;
    logic [31:0] alu_dr;
    logic [3:0]  alu_fl;

    int vec_cnt;
    int err_cnt;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .alu_ir (alu_ir),
        .sr     (sr),
        .tr     (tr),
        .alu_dr (alu_dr),
        .alu_fl (alu_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic r, input logic [31:0] ir,
                         input logic [31:0] s, input logic [31:0] t,
                         input logic [31:0] exp_dr, input logic [3:0] exp_fl);
        @(negedge clk);
        rst    = r;
        alu_ir = ir;
        sr     = s;
        tr     = t;
        @(posedge clk);
        #1;
        check({tag, ".dr"}, alu_dr, exp_dr);
        check({tag, ".fl"}, {28'd0, alu_fl}, {28'd0, exp_fl});
        $display("%-10s ir=%08h sr=%08h tr=%08h -> dr=%08h fl=%04b", tag, ir, s, t, alu_dr, alu_fl);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        alu_ir  = 32'd0;
        sr      = 32'd0;
        tr      = 32'd0;

        // reset wins over the ADD on the same edge
        apply("rst_add",  1'b1, 32'h3000_0000, 32'd1, 32'd2, 32'd0, 4'b0000);
        apply("add_1_2",  1'b0, 32'h3000_0000, 32'd1, 32'd2, 32'd3, 4'b0000);
        apply("lil_9",    1'b0, 32'h1ABC_0009, 32'd5, 32'd7, 32'd9, 4'b0000);
        apply("lil_neg",  1'b0, 32'h1000_8000, 32'd0, 32'd0, 32'hFFFF_8000, 4'b0000);
        apply("mov_16",   1'b0, 32'h2000_0000, 32'd16, 32'd3, 32'd16, 4'b0000);
        apply("sub_5_3",  1'b0, 32'h4000_0000, 32'd3, 32'd5, 32'd2, 4'b0000);
        apply("cmp_6_2",  1'b0, 32'h5000_0000, 32'd2, 32'd6, 32'd4, 4'b0000);
        apply("sub_0_1",  1'b0, 32'h4000_0000, 32'd1, 32'd0, 32'hFFFF_FFFF, 4'b1010);
        apply("nop_hold", 1'b0, 32'h0000_0000, 32'd9, 32'd9, 32'd0, 4'b1010);
        apply("add_ovf",  1'b0, 32'h3000_0000, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 4'b1001);
        apply("rsv_hold", 1'b0, 32'hF000_1234, 32'd4, 32'd4, 32'd0, 4'b1001);
        apply("and",      1'b0, 32'h6000_0000, 32'd6, 32'd11, 32'd2, 4'b0000);
        apply("or",       1'b0, 32'h7000_0000, 32'd1, 32'd8, 32'd9, 4'b0000);
        apply("xor",      1'b0, 32'h8000_0000, 32'd5, 32'd15, 32'd10, 4'b0000);
        apply("neg_15",   1'b0, 32'h9000_0000, 32'd0, 32'd15, 32'hFFFF_FFF1, 4'b1010);
        apply("not_hold", 1'b0, 32'hA000_0000, 32'd0, 32'd15, 32'hFFFF_FFF0, 4'b1010);
        apply("add_zero", 1'b0, 32'h3000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b0110);
        apply("neg_min",  1'b0, 32'h9000_0000, 32'd0, 32'h8000_0000, 32'h8000_0000, 4'b1011);
        apply("sub_ovf",  1'b0, 32'h4000_0000, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0001);
        apply("sll_3",    1'b0, 32'hB000_0300, 32'd0, 32'd5, 32'd40, 4'b0000);
        apply("sla_3",    1'b0, 32'hC000_0300, 32'd0, 32'd5, 32'd40, 4'b0000);
        apply("srl_3",    1'b0, 32'hD5A5_E3FF, 32'd0, 32'd40, 32'd5, 4'b0000);
        apply("srl_neg",  1'b0, 32'hD000_0300, 32'd0, 32'hFFFF_FFD8, 32'h1FFF_FFFB, 4'b0000);
        apply("sra_3",    1'b0, 32'hE000_0300, 32'd0, 32'd40, 32'd5, 4'b0000);
        apply("sra_neg",  1'b0, 32'hE000_0300, 32'd0, 32'hFFFF_FFD8, 32'hFFFF_FFFB, 4'b1000);
        apply("srl_cf",   1'b0, 32'hD000_0100, 32'd0, 32'd7, 32'd3, 4'b0010);
        apply("sll_cf",   1'b0, 32'hB000_0100, 32'd0, 32'h8000_0001, 32'd2, 4'b0010);
        apply("sla_sgn",  1'b0, 32'hC000_0100, 32'd0, 32'h4000_0000, 32'h8000_0000, 4'b1001);
        apply("sla_out",  1'b0, 32'hC000_0300, 32'd0, 32'h2000_0000, 32'd0, 4'b0111);
        apply("sra_n0",   1'b0, 32'hE000_0000, 32'd0, 32'hFFFF_FFD8, 32'hFFFF_FFD8, 4'b1000);
        apply("sll_n0",   1'b0, 32'hB000_0000, 32'd0, 32'd5, 32'd5, 4'b0000);
        apply("sla_n0",   1'b0, 32'hC000_0000, 32'd0, 32'h8000_0000, 32'h8000_0000, 4'b1000);
        apply("sra_31",   1'b0, 32'hE000_1F00, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1000);
        apply("rst_mid",  1'b1, 32'h3000_0000, 32'd1, 32'd2, 32'd0, 4'b0000);
        apply("add_post", 1'b0, 32'h3000_0000, 32'd1, 32'd2, 32'd3, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
